// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage RV32 pipeline: tracks rd of EX/MA/RW, drives stall, flush and forwarding.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined; otherwise they read 0.
module hazard_ctrl_unit #(
  parameter int NREG   = 32,
  parameter int FWD_EN = 1,
  localparam int RAW   = $clog2(NREG)
) (
  input  logic           clk1,
  input  logic           rst,
  input  logic           of_valid_i,
  input  logic [RAW-1:0] of_rs1_i,
  input  logic [RAW-1:0] of_rs2_i,
  input  logic           of_rs1_used_i,
  input  logic           of_rs2_used_i,
  input  logic [RAW-1:0] of_rd_i,
  input  logic           of_rd_we_i,
  input  logic           of_is_load_i,
  input  logic           ex_branch_taken_i,
  input  logic           ma_mem_ready_i,
  output logic [4:0]     stall_o,
  output logic           flush_o,
  output logic [1:0]     fwd_sel1_o,
  output logic [1:0]     fwd_sel2_o,
  output logic [31:0]    cnt_lu_stall_o,
  output logic [31:0]    cnt_mem_stall_o,
  output logic [31:0]    cnt_flush_o
);

  typedef struct packed {
    logic           valid;
    logic [RAW-1:0] rd;
    logic           we;
    logic           ld;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '0;

  function automatic logic slot_match(input slot_t s, input logic [RAW-1:0] rs, input logic used);
    return s.valid & s.we & (s.rd == rs) & (rs != {RAW{1'b0}}) & used;
  endfunction

  // An EX load cannot forward yet; a MA load forwards only once memory has answered.
  function automatic logic [1:0] fwd_pick(input slot_t ex_s, input slot_t ma_s,
                                          input logic m_ex, input logic m_ma,
                                          input logic m_rw, input logic rdy);
    logic [1:0] sel;
    sel = 2'd0;
    if (m_ex && !ex_s.ld) begin
      sel = 2'd1;
    end else if (m_ma) begin
      sel = (ma_s.ld && !rdy) ? 2'd0 : 2'd2;
    end else if (m_rw) begin
      sel = 2'd3;
    end else begin
      sel = 2'd0;
    end
    return sel;
  endfunction

  slot_t ex_q, ma_q, rw_q;
  slot_t ex_d, ma_d, rw_d;
  slot_t of_slot_s;
  logic  flush_q, flush_d;
  logic  m1_ex_s, m1_ma_s, m1_rw_s, m2_ex_s, m2_ma_s, m2_rw_s;
  logic  mem_wait_s, raw_hz_s, hz_stall_s, issue_s;
  logic [4:0] stall_s;
  logic [1:0] fwd1_s, fwd2_s;

  assign of_slot_s = {1'b1, of_rd_i, of_rd_we_i, of_is_load_i};

  // Hazard detection, stall vector, forwarding selects and tracker next state.
  always_comb begin
    m1_ex_s = slot_match(ex_q, of_rs1_i, of_rs1_used_i);
    m1_ma_s = slot_match(ma_q, of_rs1_i, of_rs1_used_i);
    m1_rw_s = slot_match(rw_q, of_rs1_i, of_rs1_used_i);
    m2_ex_s = slot_match(ex_q, of_rs2_i, of_rs2_used_i);
    m2_ma_s = slot_match(ma_q, of_rs2_i, of_rs2_used_i);
    m2_rw_s = slot_match(rw_q, of_rs2_i, of_rs2_used_i);

    mem_wait_s = ma_q.valid & ma_q.ld & ~ma_mem_ready_i;

    if (FWD_EN != 0) begin
      raw_hz_s = ex_q.ld & (m1_ex_s | m2_ex_s);
    end else begin
      raw_hz_s = m1_ex_s | m1_ma_s | m1_rw_s | m2_ex_s | m2_ma_s | m2_rw_s;
    end

    // A squashed or about-to-be-squashed OF instruction never needs to wait.
    hz_stall_s = of_valid_i & raw_hz_s & ~flush_q & ~ex_branch_taken_i & ~mem_wait_s;

    if (mem_wait_s) begin
      stall_s = 5'b01111;
    end else if (hz_stall_s) begin
      stall_s = 5'b00011;
    end else begin
      stall_s = 5'b00000;
    end

    issue_s = of_valid_i & ~stall_s[1] & ~flush_q & ~ex_branch_taken_i;

    if (FWD_EN != 0) begin
      fwd1_s = fwd_pick(ex_q, ma_q, m1_ex_s, m1_ma_s, m1_rw_s, ma_mem_ready_i);
      fwd2_s = fwd_pick(ex_q, ma_q, m2_ex_s, m2_ma_s, m2_rw_s, ma_mem_ready_i);
    end else begin
      fwd1_s = 2'd0;
      fwd2_s = 2'd0;
    end

    // A branch seen during a memory wait is held until EX can advance.
    flush_d = ex_branch_taken_i & ~mem_wait_s;

    if (mem_wait_s) begin
      ex_d = ex_q;
      ma_d = ma_q;
      rw_d = SLOT_EMPTY;
    end else begin
      ex_d = issue_s ? of_slot_s : SLOT_EMPTY;
      ma_d = ex_q;
      rw_d = ma_q;
    end
  end

  // Tracker slots and registered flush.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      ex_q    <= SLOT_EMPTY;
      ma_q    <= SLOT_EMPTY;
      rw_q    <= SLOT_EMPTY;
      flush_q <= 1'b0;
    end else begin
      ex_q    <= ex_d;
      ma_q    <= ma_d;
      rw_q    <= rw_d;
      flush_q <= flush_d;
    end
  end

  assign stall_o    = stall_s;
  assign flush_o    = flush_q;
  assign fwd_sel1_o = fwd1_s;
  assign fwd_sel2_o = fwd2_s;

`ifdef HAZARD_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? (v + 32'd1) : v;
  endfunction

  logic [31:0] cnt_lu_q, cnt_mem_q, cnt_fl_q;
  logic [31:0] cnt_lu_d, cnt_mem_d, cnt_fl_d;

  assign cnt_lu_d  = sat_inc(cnt_lu_q, hz_stall_s);
  assign cnt_mem_d = sat_inc(cnt_mem_q, mem_wait_s);
  assign cnt_fl_d  = sat_inc(cnt_fl_q, flush_q);

  // Saturating per-cycle event counters.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      cnt_lu_q  <= 32'd0;
      cnt_mem_q <= 32'd0;
      cnt_fl_q  <= 32'd0;
    end else begin
      cnt_lu_q  <= cnt_lu_d;
      cnt_mem_q <= cnt_mem_d;
      cnt_fl_q  <= cnt_fl_d;
    end
  end

  assign cnt_lu_stall_o  = cnt_lu_q;
  assign cnt_mem_stall_o = cnt_mem_q;
  assign cnt_flush_o     = cnt_fl_q;
`else
  assign cnt_lu_stall_o  = 32'd0;
  assign cnt_mem_stall_o = 32'd0;
  assign cnt_flush_o     = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: a fixed vector table, corner sequences, then random stimulus against a reference model.
// Instance A has forwarding enabled, instance B has it disabled; both share all inputs.
module tb_hazard_ctrl_unit;

  logic        clk1 = 1'b0;
  logic        rst;
  logic        of_valid, of_rs1_used, of_rs2_used, of_rd_we, of_is_load;
  logic [4:0]  of_rs1, of_rs2, of_rd;
  logic        ex_branch_taken, ma_mem_ready;
  logic [4:0]  stall_a, stall_b;
  logic        flush_a, flush_b;
  logic [1:0]  f1_a, f2_a, f1_b, f2_b;
  logic [31:0] cl_a, cm_a, cf_a, cl_b, cm_b, cf_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk1 = ~clk1;

  hazard_ctrl_unit #(.NREG(32), .FWD_EN(1)) dut_a (
    .clk1(clk1), .rst(rst), .of_valid_i(of_valid), .of_rs1_i(of_rs1), .of_rs2_i(of_rs2),
    .of_rs1_used_i(of_rs1_used), .of_rs2_used_i(of_rs2_used), .of_rd_i(of_rd),
    .of_rd_we_i(of_rd_we), .of_is_load_i(of_is_load), .ex_branch_taken_i(ex_branch_taken),
    .ma_mem_ready_i(ma_mem_ready), .stall_o(stall_a), .flush_o(flush_a),
    .fwd_sel1_o(f1_a), .fwd_sel2_o(f2_a), .cnt_lu_stall_o(cl_a),
    .cnt_mem_stall_o(cm_a), .cnt_flush_o(cf_a)
  );

  hazard_ctrl_unit #(.NREG(32), .FWD_EN(0)) dut_b (
    .clk1(clk1), .rst(rst), .of_valid_i(of_valid), .of_rs1_i(of_rs1), .of_rs2_i(of_rs2),
    .of_rs1_used_i(of_rs1_used), .of_rs2_used_i(of_rs2_used), .of_rd_i(of_rd),
    .of_rd_we_i(of_rd_we), .of_is_load_i(of_is_load), .ex_branch_taken_i(ex_branch_taken),
    .ma_mem_ready_i(ma_mem_ready), .stall_o(stall_b), .flush_o(flush_b),
    .fwd_sel1_o(f1_b), .fwd_sel2_o(f2_b), .cnt_lu_stall_o(cl_b),
    .cnt_mem_stall_o(cm_b), .cnt_flush_o(cf_b)
  );

  // Reference model: per instance, the in-flight instructions by stage (0=EX, 1=MA, 2=RW).
  typedef struct {
    bit v;
    int rd;
    bit we;
    bit ld;
  } mslot_t;

  mslot_t          ms   [2][3];
  bit              mfl  [2];
  longint unsigned mcnt [2][3];

  typedef struct {
    int v, rs1, u1, rs2, u2, rd, we, ld, bt, rdy;
    int st, fl, f1, f2;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic bit hit(int i, int k, int rs, bit used);
    return ms[i][k].v && ms[i][k].we && (ms[i][k].rd == rs) && (rs != 0) && used;
  endfunction

  // Youngest producer wins; a load still in EX has no data, a load in MA has data only when ready.
  function automatic int fsel(int i, int rs, bit used);
    int sel;
    bit done;
    sel  = 0;
    done = 0;
    for (int k = 0; k < 3; k++) begin
      if (!done && hit(i, k, rs, used)) begin
        if (k == 0) begin
          if (!ms[i][0].ld) begin
            sel  = 1;
            done = 1;
          end
        end else if (k == 1) begin
          sel  = (ms[i][1].ld && !ma_mem_ready) ? 0 : 2;
          done = 1;
        end else begin
          sel  = 3;
          done = 1;
        end
      end
    end
    return sel;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      mfl[i] = 0;
      for (int k = 0; k < 3; k++) begin
        ms[i][k]   = '{0, 0, 0, 0};
        mcnt[i][k] = 0;
      end
    end
  endtask

  task automatic set_of(input int v, input int rs1, input int u1, input int rs2, input int u2,
                        input int rd, input int we, input int ld, input int bt, input int rdy);
    of_valid        = (v != 0);
    of_rs1          = 5'(rs1);
    of_rs1_used     = (u1 != 0);
    of_rs2          = 5'(rs2);
    of_rs2_used     = (u2 != 0);
    of_rd           = 5'(rd);
    of_rd_we        = (we != 0);
    of_is_load      = (ld != 0);
    ex_branch_taken = (bt != 0);
    ma_mem_ready    = (rdy != 0);
  endtask

  // Compare both instances against the model, advance the model, then move to just after the next edge.
  task automatic tick();
    #1;
    for (int i = 0; i < 2; i++) begin
      logic [4:0]  a_st;
      logic        a_fl;
      logic [1:0]  a_f1, a_f2;
      logic [31:0] a_c [3];
      bit mw, haz, lu, issue;
      int es, ef1, ef2, rs1, rs2;
      rs1 = int'(of_rs1);
      rs2 = int'(of_rs2);
      if (i == 0) begin
        a_st = stall_a; a_fl = flush_a; a_f1 = f1_a; a_f2 = f2_a;
        a_c[0] = cl_a; a_c[1] = cm_a; a_c[2] = cf_a;
      end else begin
        a_st = stall_b; a_fl = flush_b; a_f1 = f1_b; a_f2 = f2_b;
        a_c[0] = cl_b; a_c[1] = cm_b; a_c[2] = cf_b;
      end
      mw  = ms[i][1].v && ms[i][1].ld && !ma_mem_ready;
      haz = 0;
      for (int k = 0; k < 3; k++) begin
        if (hit(i, k, rs1, of_rs1_used) || hit(i, k, rs2, of_rs2_used)) begin
          if (i == 1 || (k == 0 && ms[i][0].ld)) haz = 1;
        end
      end
      lu  = of_valid && haz && !mfl[i] && !ex_branch_taken && !mw;
      es  = mw ? 15 : (lu ? 3 : 0);
      ef1 = (i == 1) ? 0 : fsel(i, rs1, of_rs1_used);
      ef2 = (i == 1) ? 0 : fsel(i, rs2, of_rs2_used);
      chk($sformatf("dut%0d stall", i), 64'(a_st), 64'(es));
      chk($sformatf("dut%0d flush", i), 64'(a_fl), 64'(mfl[i]));
      chk($sformatf("dut%0d fwd_sel1", i), 64'(a_f1), 64'(ef1));
      chk($sformatf("dut%0d fwd_sel2", i), 64'(a_f2), 64'(ef2));
      for (int c = 0; c < 3; c++) begin
`ifdef HAZARD_PERF_CNT_EN
        chk($sformatf("dut%0d counter%0d", i, c), 64'(a_c[c]), mcnt[i][c]);
`else
        chk($sformatf("dut%0d counter%0d", i, c), 64'(a_c[c]), 64'd0);
`endif
      end
      if (lu && mcnt[i][0] < 64'hFFFF_FFFF) mcnt[i][0] += 1;
      if (mw && mcnt[i][1] < 64'hFFFF_FFFF) mcnt[i][1] += 1;
      if (mfl[i] && mcnt[i][2] < 64'hFFFF_FFFF) mcnt[i][2] += 1;
      issue = of_valid && (es == 0) && !mfl[i] && !ex_branch_taken;
      if (mw) begin
        ms[i][2].v = 0;
      end else begin
        ms[i][2] = ms[i][1];
        ms[i][1] = ms[i][0];
        if (issue) ms[i][0] = '{1, int'(of_rd), of_rd_we, of_is_load};
        else       ms[i][0] = '{0, 0, 0, 0};
      end
      mfl[i] = ex_branch_taken && !mw;
    end
    cyc++;
    @(posedge clk1);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " stall_a"}, 64'(stall_a), 64'd0);
    chk({tag, " stall_b"}, 64'(stall_b), 64'd0);
    chk({tag, " flush"}, 64'({flush_a, flush_b}), 64'd0);
    chk({tag, " fwd"}, 64'({f1_a, f2_a, f1_b, f2_b}), 64'd0);
    chk({tag, " counters"}, 64'(cl_a | cm_a | cf_a | cl_b | cm_b | cf_b), 64'd0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    chk_all_zero(tag);
    set_of(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    model_clear();
    @(negedge clk1);
    rst = 1'b0;
    @(posedge clk1);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1;
    set_of(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    model_clear();

    //           v rs1 u1 rs2 u2 rd we ld bt rdy  st fl f1 f2
    tbl[0]  = '{1, 0, 0, 0, 0,  5, 1, 1, 0, 1,   0, 0, 0, 0}; // lw x5
    tbl[1]  = '{1, 5, 1, 0, 1,  6, 1, 0, 0, 1,   3, 0, 0, 0}; // add x6,x5,x0: load-use
    tbl[2]  = '{1, 5, 1, 0, 1,  6, 1, 0, 0, 1,   0, 0, 2, 0}; // retry: forward from MA
    tbl[3]  = '{1, 1, 1, 6, 1,  7, 1, 0, 0, 1,   0, 0, 0, 1}; // sub x7,x1,x6: EX forward
    tbl[4]  = '{1, 7, 1, 0, 1,  0, 1, 0, 0, 1,   0, 0, 1, 0}; // writes x0
    tbl[5]  = '{1, 6, 1, 0, 1,  8, 1, 0, 0, 1,   0, 0, 3, 0}; // rs2=x0 vs rd=x0: no forward
    tbl[6]  = '{1, 0, 0, 0, 0,  9, 1, 1, 0, 1,   0, 0, 0, 0}; // lw x9
    tbl[7]  = '{1, 0, 0, 0, 0, 10, 1, 0, 0, 1,   0, 0, 0, 0};
    tbl[8]  = '{1, 9, 1, 0, 0, 11, 1, 0, 0, 0,  15, 0, 0, 0}; // memory wait x3
    tbl[9]  = '{1, 9, 1, 0, 0, 11, 1, 0, 0, 0,  15, 0, 0, 0};
    tbl[10] = '{1, 9, 1, 0, 0, 11, 1, 0, 0, 0,  15, 0, 0, 0};
    tbl[11] = '{1, 9, 1, 0, 0, 11, 1, 0, 0, 1,   0, 0, 2, 0}; // released
    tbl[12] = '{1,11, 1, 0, 0, 12, 1, 0, 1, 1,   0, 0, 1, 0}; // branch taken
    tbl[13] = '{1,11, 1, 0, 0, 13, 1, 0, 0, 1,   0, 1, 2, 0}; // flush cycle
    tbl[14] = '{1,13, 1,11, 1, 14, 1, 0, 0, 1,   0, 0, 0, 3}; // x13 never tracked
    tbl[15] = '{0,14, 1, 0, 0,  0, 0, 0, 0, 1,   0, 0, 1, 0};

    do_reset("reset");

    for (int t = 0; t < 16; t++) begin
      set_of(tbl[t].v, tbl[t].rs1, tbl[t].u1, tbl[t].rs2, tbl[t].u2,
             tbl[t].rd, tbl[t].we, tbl[t].ld, tbl[t].bt, tbl[t].rdy);
      #2;
      chk($sformatf("vec%0d stall", t), 64'(stall_a), 64'(tbl[t].st));
      chk($sformatf("vec%0d flush", t), 64'(flush_a), 64'(tbl[t].fl));
      chk($sformatf("vec%0d fwd_sel1", t), 64'(f1_a), 64'(tbl[t].f1));
      chk($sformatf("vec%0d fwd_sel2", t), 64'(f2_a), 64'(tbl[t].f2));
      tick();
    end

    // x7 produced in RW and again in EX: youngest forwards; without forwarding, stall until RW retires.
    do_reset("reset2");
    set_of(1, 0, 0, 0, 0, 7, 1, 0, 0, 1); tick();
    set_of(1, 0, 0, 0, 0, 1, 1, 0, 0, 1); tick();
    set_of(1, 0, 0, 0, 0, 7, 1, 0, 0, 1); tick();
    set_of(1, 7, 1, 0, 0, 2, 1, 0, 0, 1);
    #2;
    chk("youngest fwd_sel1", 64'(f1_a), 64'd1);
    chk("youngest stall fwd", 64'(stall_a), 64'd0);
    chk("youngest stall nofwd", 64'(stall_b), 64'd3);
    n = 0;
    while (stall_b == 5'b00011 && n < 10) begin
      n++;
      tick();
    end
    chk("nofwd raw stall cycles", 64'(n), 64'd3);

    // Reset in the middle of a memory wait, then a normal load-use.
    do_reset("reset3");
    set_of(1, 0, 0, 0, 0, 9, 1, 1, 0, 1); tick();
    set_of(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    set_of(1, 9, 1, 0, 0, 3, 1, 0, 0, 0);
    #2;
    chk("memwait before rst", 64'(stall_a), 64'd15);
    tick();
    #1;
    do_reset("async rst in memwait");
    set_of(1, 0, 0, 0, 0, 5, 1, 1, 0, 1); tick();
    set_of(1, 5, 1, 0, 0, 6, 1, 0, 0, 1);
    #2;
    chk("load-use after rst", 64'(stall_a), 64'd3);
    tick();

    for (int r = 0; r < 3000; r++) begin
      set_of(($urandom_range(0, 9) < 8) ? 1 : 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
             int'($urandom_range(0, 7)), int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
             ($urandom_range(0, 9) < 8) ? 1 : 0, ($urandom_range(0, 9) < 3) ? 1 : 0,
             ($urandom_range(0, 9) == 0) ? 1 : 0, ($urandom_range(0, 3) != 0) ? 1 : 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
# hazard_ctrl_unit

Parametrised hazard controller for the 5-stage RV32 pipeline, replacing the fixed load-use stall logic and the forwarding comparators in the top level. It mirrors the destination registers of instructions in EX, MA and RW, and drives the stall vector, the branch flush pulse and operand-forwarding selects. It also adds multi-cycle data-memory wait handling, which the current design lacks. All state advances on clk1.

## Interface
- NREG, 32: architectural register count; RAW = $clog2(NREG) is the register-index width
- FWD_EN, 1: 1 = forwarding selects active; 0 = fwd selects forced to 0 and every RAW on an in-flight rd stalls until RW retires
- clk1  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- of_valid  in  1  OF holds a valid instruction
- of_rs1 / of_rs2  in  RAW each  source indices of the instruction in OF
- of_rs1_used / of_rs2_used  in  1 each  source actually read
- of_rd  in  RAW  destination of the instruction in OF
- of_rd_we  in  1  OF instruction writes rd
- of_is_load  in  1  OF instruction is a load
- ex_branch_taken  in  1  branch resolved taken in EX
- ma_mem_ready  in  1  data memory done this cycle; only meaningful when the MA slot holds a load
- stall  out  5  stall[k] holds pipeline register k (1=IF … 5=RW)
- flush  out  1  squash IF/OF contents
- fwd_sel1 / fwd_sel2  out  2 each  0 = regfile, 1 = EX alu result, 2 = MA result, 3 = RW write data
- cnt_lu_stall, cnt_mem_stall, cnt_flush  out  32 each  performance counters

## Operation
- Tracker: three slots (EX, MA, RW), each holding {valid, rd, we, is_load}. The OF instruction enters EX on an issue cycle: not stall[2], not flush, and no branch taken.
- Normal advance, no stall: EX→MA→RW; RW slot discarded.
- Register index 0 never creates a hazard and never forwards.
- Match rule: a slot matches rsN when valid & we & rd==rsN & rsN!=0 & rsN_used.
- Load-use: EX slot is a load and matches either OF source → stall[2:1]=2'b11 for one cycle. EX slot becomes a bubble; MA and RW advance.
- Memory wait: MA slot is a load and !ma_mem_ready → stall[4:1]=4'hF. RW slot becomes a bubble; EX and MA hold.
- Branch: when ex_branch_taken=1, the OF instruction is not inserted into EX at the next edge (bubble). Registered flush=1 the following cycle; during that flush cycle no issue occurs either.
- Priority, highest first: rst, memory wait, branch, load-use.
  - A branch taken while memory wait is active is held. ex_branch_taken must stay asserted until EX advances.
  - Load-use is suppressed while flush=1.
- Forwarding, FWD_EN=1: youngest match wins, in the order EX (non-load only), MA, RW.
  - A MA load match selects 2 only when ma_mem_ready=1; otherwise the memory-wait stall covers it.
- FWD_EN=0: any match in any slot stalls stall[2:1]; fwd_sel=0.
- stall[5] is always 0.

## Timing
- stall and fwd_sel are combinational from tracker state and OF inputs, valid within the same cycle. flush is registered; latency is 1 cycle from ex_branch_taken.
- Reset values: all slots invalid, stall=0, flush=0, fwd_sel=0, counters=0. Reset mid-stall clears everything at once, with no residual bubble.
- Counters: +1 per cycle of the corresponding condition (load-use stall, memory-wait stall, flush=1). Counters saturate at 32'hFFFF_FFFF.
- Back-to-back loads to the same rd: each load is tracked independently. The youngest match determines the forward source.

## Configuration
- HAZARD_PERF_CNT_EN defined: the three 32-bit counters are implemented as specified.
- HAZARD_PERF_CNT_EN undefined: the counter registers are removed and the outputs are tied to 0. All other behaviour is identical.

## Test plan
- Load-use stall: lw x5 in EX; OF add with rs1=x5 → stall=5'b00011 for one cycle. Next cycle fwd_sel1=2 and stall=0.
- EX forward: add x3 in EX; OF sub with rs2=x3 → fwd_sel2=1, stall=0. Same case with rs2=x0 and rd=x0 → fwd_sel2=0.
- Memory wait: load in MA, ma_mem_ready low for 3 cycles → stall=5'b01111 for exactly 3 cycles; RW slot bubble; released on ready.
- Branch: ex_branch_taken pulse at cycle N → flush=1 at N+1 only. The OF instruction is never tracked in EX; cnt_flush increments by 1.
- Youngest wins: x7 written by instructions in both EX (ALU) and RW → fwd_sel1=1. FWD_EN=0 build: same case → stall[2:1]=2'b11 until RW retires.
- rst asserted during memory wait → all outputs 0 asynchronously. After release, the first load-use is detected normally.
